// File: rtl/conv_seq.sv
// Kernel-window sequencer: drives line-buffer writes and emits one window per pixel with edge masks.
// Optional framing check on s_tlast_i is built when CONV_SEQ_FRAME_CHECK_EN is defined.
module conv_seq #(
  parameter  int KERNEL_DIAMETER_N = 5,
  parameter  int MAX_WIDTH         = 1024,
  parameter  int MAX_HEIGHT        = 1024,
  localparam int R      = (KERNEL_DIAMETER_N - 1) / 2,
  localparam int COL_W  = $clog2(MAX_WIDTH),
  localparam int ROW_W  = $clog2(MAX_HEIGHT),
  localparam int BANK_W = $clog2(KERNEL_DIAMETER_N)
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic [COL_W-1:0]             cfg_width_i,
  input  logic [ROW_W-1:0]             cfg_height_i,
  input  logic                         s_tvalid_i,
  input  logic                         s_tlast_i,
  input  logic                         s_tuser_i,
  output logic                         s_tready_o,
  output logic                         lb_wr_o,
  output logic [COL_W-1:0]             lb_addr_o,
  output logic [BANK_W-1:0]            lb_bank_o,
  output logic                         m_tvalid_o,
  input  logic                         m_tready_i,
  output logic                         m_tuser_o,
  output logic                         m_tlast_o,
  output logic [KERNEL_DIAMETER_N-1:0] m_vmask_o,
  output logic [KERNEL_DIAMETER_N-1:0] m_hmask_o,
  output logic                         frame_err_o
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   in_col_q, in_col_d, cfg_w_q, cfg_w_d, fl_col_q, fl_col_d;
  logic [ROW_W-1:0]   in_row_q, in_row_d, cfg_h_q, cfg_h_d, fl_row_q, fl_row_d;
  logic [BANK_W-1:0]  bank_q, bank_d;

  logic [COL_W-1:0]   cur_w;
  logic [ROW_W-1:0]   cur_h;
  logic               col_last, row_last;
  logic [ROW_W-1:0]   out_row;
  logic [COL_W-1:0]   out_col;

  // The SOF beat arrives in IDLE before cfg is latched, so compare against the live inputs there.
  assign cur_w    = (state_q == IDLE) ? cfg_width_i  : cfg_w_q;
  assign cur_h    = (state_q == IDLE) ? cfg_height_i : cfg_h_q;
  assign col_last = (in_col_q == cur_w);
  assign row_last = (in_row_q == cur_h);

  assign lb_addr_o = in_col_q;
  assign lb_bank_o = bank_q;

  always_comb begin
    s_tready_o = 1'b1;
    m_tvalid_o = 1'b0;
    lb_wr_o    = 1'b0;
    state_d    = state_q;
    in_col_d   = in_col_q;
    in_row_d   = in_row_q;
    bank_d     = bank_q;
    cfg_w_d    = cfg_w_q;
    cfg_h_d    = cfg_h_q;
    fl_col_d   = fl_col_q;
    fl_row_d   = fl_row_q;

    unique case (state_q)
      IDLE:  lb_wr_o = s_tvalid_i & s_tuser_i;
      PRIME: lb_wr_o = s_tvalid_i;
      RUN: begin
        s_tready_o = m_tready_i;
        m_tvalid_o = s_tvalid_i;
        lb_wr_o    = s_tvalid_i & m_tready_i;
      end
      FLUSH: begin
        s_tready_o = 1'b0;
        m_tvalid_o = 1'b1;
      end
      default: ;
    endcase

    // lb_wr_o doubles as "input beat consumed" in every state that takes pixels.
    if (lb_wr_o) begin
      if (state_q == IDLE) begin
        cfg_w_d = cfg_width_i;
        cfg_h_d = cfg_height_i;
        state_d = PRIME;
      end
      if (col_last) begin
        in_col_d = '0;
        in_row_d = in_row_q + 1'b1;
        bank_d   = (bank_q == BANK_W'(KERNEL_DIAMETER_N - 1)) ? '0 : bank_q + 1'b1;
        if (row_last) begin
          state_d  = FLUSH;
          in_row_d = '0;
          bank_d   = '0;
          fl_col_d = '0;
          fl_row_d = (state_q == RUN) ? cfg_h_q - ROW_W'(R - 1) : '0;
        end else if (state_q != RUN && in_row_q == ROW_W'(R - 1)) begin
          state_d = RUN;
        end
      end else begin
        in_col_d = in_col_q + 1'b1;
      end
    end

    if (state_q == FLUSH && m_tready_i) begin
      if (fl_col_q == cfg_w_q) begin
        fl_col_d = '0;
        if (fl_row_q == cfg_h_q) begin
          state_d  = IDLE;
          fl_row_d = '0;
        end else begin
          fl_row_d = fl_row_q + 1'b1;
        end
      end else begin
        fl_col_d = fl_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      state_q  <= IDLE;
      in_col_q <= '0;
      in_row_q <= '0;
      bank_q   <= '0;
      cfg_w_q  <= '0;
      cfg_h_q  <= '0;
      fl_col_q <= '0;
      fl_row_q <= '0;
    end else begin
      state_q  <= state_d;
      in_col_q <= in_col_d;
      in_row_q <= in_row_d;
      bank_q   <= bank_d;
      cfg_w_q  <= cfg_w_d;
      cfg_h_q  <= cfg_h_d;
      fl_col_q <= fl_col_d;
      fl_row_q <= fl_row_d;
    end
  end

  // In RUN the window centre lags the input by R rows; FLUSH walks the remaining rows itself.
  assign out_row   = (state_q == FLUSH) ? fl_row_q : in_row_q - ROW_W'(R);
  assign out_col   = (state_q == FLUSH) ? fl_col_q : in_col_q;
  assign m_tuser_o = m_tvalid_o && (out_row == '0) && (out_col == '0);
  assign m_tlast_o = m_tvalid_o && (out_col == cfg_w_q);

  localparam logic signed [ROW_W:0] R_ROW = R;
  localparam logic signed [COL_W:0] R_COL = R;

  for (genvar i = 0; i < KERNEL_DIAMETER_N; i++) begin : g_tap
    localparam logic signed [ROW_W:0] I_ROW = i;
    localparam logic signed [COL_W:0] I_COL = i;
    logic signed [ROW_W:0] vr;
    logic signed [COL_W:0] hc;
    assign vr = $signed({1'b0, out_row}) - R_ROW + I_ROW;
    assign hc = $signed({1'b0, out_col}) - R_COL + I_COL;
    assign m_vmask_o[i] = m_tvalid_o && !vr[ROW_W] && (vr <= $signed({1'b0, cfg_h_q}));
    assign m_hmask_o[i] = m_tvalid_o && !hc[COL_W] && (hc <= $signed({1'b0, cfg_w_q}));
  end

`ifdef CONV_SEQ_FRAME_CHECK_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q;
    if ((state_q == PRIME || state_q == RUN) && lb_wr_o && (s_tlast_i != col_last))
      err_d = 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_n) err_q <= 1'b0;
    else       err_q <= err_d;
  end
  assign frame_err_o = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_tlast_i;
  assign frame_err_o  = 1'b0;
`endif

endmodule

// File: doc/conv_seq.md
CONV_SEQ -- requirements
Module: conv_seq

Interface
REQ-001 The block SHALL have parameter KERNEL_DIAMETER_N, default 5, giving the kernel diameter; it must be odd and >= 3; R = (KERNEL_DIAMETER_N-1)/2.
REQ-002 The block SHALL have parameter MAX_WIDTH, default 1024, giving the maximum line length in pixels; COL_W = $clog2(MAX_WIDTH).
REQ-003 The block SHALL have parameter MAX_HEIGHT, default 1024, giving the maximum frame height in lines; ROW_W = $clog2(MAX_HEIGHT).
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk_i  input  1  clock; the block SHALL have one clock only.
- rst_n  input  1  reset; synchronous and active-high (asserted = 1) despite the name.
- cfg_width_i  input  COL_W  line width minus 1; sampled at start of frame (SOF).
- cfg_height_i  input  ROW_W  frame height minus 1; sampled at SOF.
- s_tvalid_i  input  1  upstream pixel valid.
- s_tlast_i  input  1  upstream end of line.
- s_tuser_i  input  1  upstream start of frame.
- s_tready_o  output  1  upstream ready.
- lb_wr_o  output  1  line-buffer write strobe.
- lb_addr_o  output  COL_W  line-buffer column address.
- lb_bank_o  output  $clog2(KERNEL_DIAMETER_N)  line-buffer bank currently written.
- m_tvalid_o  output  1  kernel window valid.
- m_tready_i  input  1  downstream ready.
- m_tuser_o  output  1  first window of the frame.
- m_tlast_o  output  1  last window of a line.
- m_vmask_o  output  KERNEL_DIAMETER_N  vertical in-frame tap mask.
- m_hmask_o  output  KERNEL_DIAMETER_N  horizontal in-frame tap mask.
- frame_err_o  output  1  sticky framing error (gated by the macro in REQ-020).

Function
REQ-005 The block SHALL be an FSM with states IDLE, PRIME, RUN, FLUSH, updated on the rising edge of clk_i.
REQ-006 An input beat is accepted when s_tvalid_i & s_tready_o; an output beat completes when m_tvalid_o & m_tready_i.
REQ-007 IDLE: s_tready_o=1; accepted beats with s_tuser_i=0 are discarded (lb_wr_o=0).
- An accepted beat with s_tuser_i=1 latches cfg_*, writes column 0 of bank 0, and moves to PRIME (R>0).
REQ-008 PRIME: s_tready_o=1, m_tvalid_o=0; each accepted beat asserts lb_wr_o combinationally that cycle.
REQ-009 Input column counter (lb_addr_o) wraps to 0 after cfg_width.
- At wrap, lb_bank_o advances modulo KERNEL_DIAMETER_N and the input row counter increments.
REQ-010 PRIME -> RUN when input row R-1 completes.
- If the final input row (cfg_height) completes while in PRIME, the FSM SHALL go PRIME -> FLUSH instead.
REQ-011 RUN: m_tvalid_o = s_tvalid_i, s_tready_o = m_tready_i; one accepted input produces exactly one output window in the same cycle (zero latency).
- Output row = input row - R; output column = input column.
REQ-012 RUN -> FLUSH when the last input column of row cfg_height is accepted.
REQ-013 FLUSH: s_tready_o=0, lb_wr_o=0, m_tvalid_o=1; an internal column counter advances on each completed output beat.
- FLUSH -> IDLE on the completed beat at output row cfg_height, column cfg_width.
REQ-014 Every frame SHALL produce exactly (cfg_height+1)*(cfg_width+1) output beats.
REQ-015 m_tuser_o=1 only on output row 0, column 0; m_tlast_o=1 on every output column cfg_width.
REQ-016 m_vmask_o[i]=1 iff (out_row - R + i) lies in [0, cfg_height].
- m_hmask_o[i]=1 iff (out_col - R + i) lies in [0, cfg_width].
- Computed with ROW_W+1 / COL_W+1 bit signed arithmetic.
REQ-017 Whenever m_tvalid_o=1, outputs SHALL hold stable until the beat completes (no change while m_tready_i=0).
REQ-018 s_tuser_i=1 accepted outside IDLE SHALL be treated as ordinary data; the frame is not restarted.

Reset
REQ-019 With rst_n=1 at a clock edge, the next cycle SHALL show:
- state IDLE;
- all counters, lb_bank_o and lb_addr_o = 0;
- m_tvalid_o, m_tuser_o, m_tlast_o, lb_wr_o, frame_err_o = 0;
- masks = 0;
- s_tready_o = 1.
- Reset mid-frame SHALL abandon the frame with no further output beats.

Configuration
REQ-020 Macro CONV_SEQ_FRAME_CHECK_EN controls framing checks.
- Defined: frame_err_o sets and holds until reset on an accepted s_tlast_i that mismatches column==cfg_width in PRIME/RUN; counters follow cfg_width regardless of s_tlast_i.
- Undefined: frame_err_o is tied 0 and no check logic is built.

Verification
REQ-021 K=5, width=3 (cfg 2), height=4 (cfg 3), always ready -> PRIME 6 beats; RUN 6 windows; FLUSH 6 windows; total 12; m_tuser_o on first only.
REQ-022 Same frame, row 0 col 0 window -> m_vmask_o=5'b11100, m_hmask_o=5'b11100; last window -> both 5'b00111.
REQ-023 RUN with m_tready_i toggling 0/1 every cycle -> s_tready_o tracks m_tready_i; no beat is lost or duplicated; outputs stable while stalled.
REQ-024 K=5, cfg_height=0 (1 row), width 4 -> FSM goes PRIME -> FLUSH; exactly 4 windows; m_vmask_o=5'b00100.
REQ-025 rst_n asserted during RUN row 2 -> next cycle IDLE with outputs zeroed; the following SOF frame completes correctly.
REQ-026 With CONV_SEQ_FRAME_CHECK_EN defined, s_tlast_i at column 1 when cfg_width=2 -> frame_err_o=1 the next cycle, held until reset.
